// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: ALU opcode encoding and default datapath widths.
// Used by the ID/EX stage and the ALU so both agree on operand width and opcodes.
package id_ex_stage_pkg;

    localparam int CPU_DATA_W  = 32;
    localparam int CPU_RADDR_W = 5;
    localparam int IMM_W       = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b100,
        ALU_AND = 3'b001,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b010,
        ALU_LUI = 3'b110
    } alu_op_e;

    // Arithmetic ops take a signed immediate; logical ops, lui and any
    // unassigned encodings take it zero-extended.
    function automatic logic imm_is_signed(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage : id_ex_stage_pkg

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID/EX stage's decode-side, forwarding, control and execute-side
// signals. master = the surrounding pipeline, slave = the ID/EX stage itself.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int RADDR_W = CPU_RADDR_W
);
    // Decode-side handshake and instruction fields
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [RADDR_W-1:0] in_rs_addr;
    logic [RADDR_W-1:0] in_rt_addr;
    logic [DATA_W-1:0]  in_rs_data;
    logic [DATA_W-1:0]  in_rt_data;
    logic [IMM_W-1:0]   in_imm;
    logic               in_use_imm;
    logic [RADDR_W-1:0] in_rd_addr;
    logic               in_wr_en;

    // Forwarding sources: EX/MEM (fwd1) and MEM/WB (fwd2)
    logic               fwd1_wr_en;
    logic               fwd1_is_load;
    logic [RADDR_W-1:0] fwd1_addr;
    logic [DATA_W-1:0]  fwd1_data;
    logic               fwd2_wr_en;
    logic [RADDR_W-1:0] fwd2_addr;
    logic [DATA_W-1:0]  fwd2_data;

    // Pipeline control
    logic               flush;
    logic               ex_ready;

    // Execute-side outputs
    logic               out_valid;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [2:0]         alu_op;
    logic [RADDR_W-1:0] out_rd_addr;
    logic               out_wr_en;
    logic [15:0]        stall_cnt;

    modport master (
        output in_valid, in_op, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_rd_addr, in_wr_en,
               fwd1_wr_en, fwd1_is_load, fwd1_addr, fwd1_data,
               fwd2_wr_en, fwd2_addr, fwd2_data, flush, ex_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd_addr,
               out_wr_en, stall_cnt
    );

    modport slave (
        input  in_valid, in_op, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_rd_addr, in_wr_en,
               fwd1_wr_en, fwd1_is_load, fwd1_addr, fwd1_data,
               fwd2_wr_en, fwd2_addr, fwd2_data, flush, ex_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd_addr,
               out_wr_en, stall_cnt
    );

endinterface : id_ex_stage_if

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding select. Resolves one source register to the newest
// available value: EX/MEM result, then MEM/WB result, then the register file.
// Register 0 is hard-wired to zero and never forwarded.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int RADDR_W = CPU_RADDR_W
) (
    input  logic [RADDR_W-1:0] src_addr_i,
    input  logic [DATA_W-1:0]  rf_data_i,
    input  logic               fwd1_wr_en_i,
    input  logic [RADDR_W-1:0] fwd1_addr_i,
    input  logic [DATA_W-1:0]  fwd1_data_i,
    input  logic               fwd2_wr_en_i,
    input  logic [RADDR_W-1:0] fwd2_addr_i,
    input  logic [DATA_W-1:0]  fwd2_data_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               fwd1_hit_o
);

    logic src_is_zero;
    logic fwd2_hit;

    assign src_is_zero = (src_addr_i == '0);
    assign fwd1_hit_o  = fwd1_wr_en_i && (fwd1_addr_i == src_addr_i) && !src_is_zero;
    assign fwd2_hit    = fwd2_wr_en_i && (fwd2_addr_i == src_addr_i) && !src_is_zero;

    // Priority select: zero register, then youngest producer, then register file
    always_comb begin
        // NOTE: every path assigns data_o (default first), so no latch is inferred.
        data_o = rf_data_i;
        if (src_is_zero) begin
            data_o = '0;
        end else if (fwd1_hit_o) begin
            data_o = fwd1_data_i;
        end else if (fwd2_hit) begin
            data_o = fwd2_data_i;
        end
    end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Resolves forwarded operands and the extended
// immediate, detects load-use hazards, and holds one instruction for the
// execute stage under a valid/ready handshake with flush and backpressure.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int RADDR_W = CPU_RADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    // Resolved operands
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              rs_fwd1_hit;
    logic              rt_fwd1_hit;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] opnd_b;

    // Handshake
    logic hazard;
    logic in_ready;
    logic capture;

    // Pipeline register state
    logic               valid_q,  valid_d;
    logic [DATA_W-1:0]  alu_a_q,  alu_a_d;
    logic [DATA_W-1:0]  alu_b_q,  alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [RADDR_W-1:0] rd_q,     rd_d;
    logic               wr_en_q,  wr_en_d;
    logic [15:0]        stall_q,  stall_d;

    fwd_mux #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs (
        .src_addr_i   (bus.in_rs_addr),
        .rf_data_i    (bus.in_rs_data),
        .fwd1_wr_en_i (bus.fwd1_wr_en),
        .fwd1_addr_i  (bus.fwd1_addr),
        .fwd1_data_i  (bus.fwd1_data),
        .fwd2_wr_en_i (bus.fwd2_wr_en),
        .fwd2_addr_i  (bus.fwd2_addr),
        .fwd2_data_i  (bus.fwd2_data),
        .data_o       (rs_val),
        .fwd1_hit_o   (rs_fwd1_hit)
    );

    fwd_mux #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rt (
        .src_addr_i   (bus.in_rt_addr),
        .rf_data_i    (bus.in_rt_data),
        .fwd1_wr_en_i (bus.fwd1_wr_en),
        .fwd1_addr_i  (bus.fwd1_addr),
        .fwd1_data_i  (bus.fwd1_data),
        .fwd2_wr_en_i (bus.fwd2_wr_en),
        .fwd2_addr_i  (bus.fwd2_addr),
        .fwd2_data_i  (bus.fwd2_data),
        .data_o       (rt_val),
        .fwd1_hit_o   (rt_fwd1_hit)
    );

    // Immediate extension and operand-b select
    always_comb begin
        if (imm_is_signed(bus.in_op)) begin
            imm_ext = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
        end else begin
            imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.in_imm};
        end
        opnd_b = bus.in_use_imm ? imm_ext : rt_val;
    end

    // A load in EX/MEM cannot forward yet; stall any consumer of its result.
    // rt only counts as a consumer when the immediate is not replacing it.
    assign hazard   = bus.in_valid && bus.fwd1_is_load &&
                      (rs_fwd1_hit || (!bus.in_use_imm && rt_fwd1_hit));
    assign in_ready = (!valid_q || bus.ex_ready) && !hazard && !bus.flush;
    assign capture  = bus.in_valid && in_ready;

    // Next-state: flush beats capture/hold; capture beats drain; otherwise hold
    always_comb begin
        valid_d  = valid_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rd_d     = rd_q;
        wr_en_d  = wr_en_q;
        stall_d  = stall_q;

        if (hazard && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d  = 1'b1;
            alu_a_d  = rs_val;
            alu_b_d  = opnd_b;
            alu_op_d = bus.in_op;
            rd_d     = bus.in_rd_addr;
            wr_en_d  = bus.in_wr_en;
        end else if (valid_q && bus.ex_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register with asynchronous clear of every output
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update together.
        if (!rst_n) begin
            valid_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rd_q     <= '0;
            wr_en_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            rd_q     <= rd_d;
            wr_en_q  <= wr_en_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.out_rd_addr = rd_q;
    // A stale write enable must never escape while no instruction is held
    assign bus.out_wr_en   = wr_en_q && valid_q;
    assign bus.stall_cnt   = stall_q;

endmodule : id_ex_stage
